// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared address-width and reset-vector constants for the PC.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

    typedef logic [XLEN-1:0] addr_t;

endpackage
`default_nettype wire

// File: rtl/program_counter.sv
`default_nettype none
// ============================================================================
// Module      : program_counter
// Description : PC register; loads the next-PC value every cycle, with a
//               synchronous reset to RESET_VECTOR.
// Revision    : 1.0 - initial release
// ============================================================================
module program_counter #(
    parameter int              XLEN         = pc_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = pc_pkg::RESET_VECTOR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    output logic [XLEN-1:0] pc_out
);

    logic [XLEN-1:0] r_pc;

    // No masking, increment or saturation: the datapath owns next-PC policy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_VECTOR;
        end else begin
            r_pc <= pc_in;
        end
    end

    assign pc_out = r_pc;

`ifndef SYNTHESIS
    logic            r_armed;
    logic            r_last_reset;
    logic [XLEN-1:0] r_last_pc_in;

    // pc_out read here is the value produced by the previous edge.
    always_ff @(posedge clk) begin
        if (r_armed) begin
            if (r_last_reset) begin
                assert (pc_out === RESET_VECTOR);
            end else begin
                assert (pc_out === r_last_pc_in);
            end
            assert (!$isunknown(pc_out));
        end
        r_armed      <= (r_armed === 1'b1) || reset;
        r_last_reset <= reset;
        r_last_pc_in <= pc_in;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_program_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_counter
// Description : Self-checking bench for program_counter (default and 0x1000
//               reset vector instances) against a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_counter;

    localparam logic [31:0] RV_ALT = 32'h0000_1000;

    logic          clk = 1'b0;
    logic          reset;
    pc_pkg::addr_t pc_in;
    pc_pkg::addr_t pc_out;
    pc_pkg::addr_t pc_out_rv;

    int            total = 0;
    int            bad   = 0;
    logic [31:0]   model_pc;
    logic [31:0]   model_pc_rv;

    program_counter dut (
        .clk    (clk),
        .reset  (reset),
        .pc_in  (pc_in),
        .pc_out (pc_out)
    );

    program_counter #(
        .XLEN         (32),
        .RESET_VECTOR (RV_ALT)
    ) dut_rv (
        .clk    (clk),
        .reset  (reset),
        .pc_in  (pc_in),
        .pc_out (pc_out_rv)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive from the falling edge, wiggle pc_in before settling,
    // confirm the output held, then check both instances after the edge.
    task automatic cycle(input logic r, input logic [31:0] p, input string tag);
        @(negedge clk);
        reset = r;
        pc_in = p;
        #3 pc_in = $urandom;
        #3 pc_in = p;
        check({tag, "_hold"}, pc_out, model_pc);
        @(posedge clk);
        model_pc    = r ? 32'h0000_0000 : p;
        model_pc_rv = r ? RV_ALT        : p;
        #1;
        check(tag, pc_out, model_pc);
        check({tag, "_rv"}, pc_out_rv, model_pc_rv);
    endtask

    initial begin
        reset = 1'b1;
        pc_in = 32'h0;
        @(posedge clk);
        model_pc    = 32'h0;
        model_pc_rv = RV_ALT;
        #1;
        check("reset", pc_out, model_pc);
        check("reset_rv", pc_out_rv, model_pc_rv);

        cycle(1'b0, 32'd50,  "unaligned_50");
        cycle(1'b0, 32'd100, "load_100");
        cycle(1'b1, 32'd100, "mid_reset");
        cycle(1'b0, 32'd200, "after_reset_200");
        cycle(1'b0, model_pc + 32'd4, "plus4");
        cycle(1'b0, 32'hFFFF_FFFC, "top_addr");
        cycle(1'b0, model_pc + 32'd4, "wrap_zero");
        cycle(1'b1, 32'hDEAD_BEEF, "reset_deadbeef");
        cycle(1'b0, 32'hDEAD_BEEF, "load_deadbeef");

        for (int i = 0; i < 300; i++) begin
            logic        r;
            logic [31:0] p;
            r = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0:       p = model_pc + 32'd4;
                1:       p = 32'hFFFF_FFFC + 32'($urandom_range(0, 7));
                default: p = $urandom;
            endcase
            cycle(r, p, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
